// File: rtl/psec6_readout_pkg.sv
// Constants and types shared by the per-channel timestamp serializers and the
// readout multiplexer that selects between their POCI bits.
package psec6_readout_pkg;

  localparam int CH_REG_START_ADDR = 12;
  localparam int NUM_REGS_PER_CH   = 7;
  localparam int NUM_CH            = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } snap_state_t;

  // First SPI register address owned by channel idx.
  function automatic int ch_base(input int idx);
    return CH_REG_START_ADDR + idx * NUM_REGS_PER_CH;
  endfunction

endpackage

// File: rtl/byte_shifter.sv
// MSB-first byte shifter: loads a byte on a matching read, then shifts it out
// over the following seven read edges; o_wrap marks the edge that shows bit 0.
module byte_shifter (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_cs,
  input  logic       i_rd_en,
  input  logic       i_match,
  input  logic [7:0] i_byte,
  output logic       o_load,
  output logic       o_wrap,
  output logic       o_sdo
);

  logic [7:0] r_sh;
  logic [2:0] r_bcnt;

  assign o_load = i_cs & i_rd_en & i_match & (r_bcnt == 3'd0);
  assign o_wrap = i_cs & i_rd_en & (r_bcnt == 3'd7);
  assign o_sdo  = r_sh[7];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sh   <= 8'h00;
      r_bcnt <= 3'd0;
    end else if (!i_cs) begin
      r_sh   <= 8'h00;
      r_bcnt <= 3'd0;
    end else if (i_rd_en) begin
      // Once a byte is in flight the address is not looked at again.
      if (r_bcnt != 3'd0) begin
        r_sh   <= r_sh << 1;
        r_bcnt <= r_bcnt + 3'd1;
      end else if (i_match) begin
        r_sh   <= i_byte;
        r_bcnt <= 3'd1;
      end
    end
  end

endmodule

// File: rtl/ch_timestamp_serializer.sv
// Per-channel timestamp snapshot held as SPI-readable byte registers and
// serialized MSB-first onto this channel's POCI line.
module ch_timestamp_serializer #(
  parameter int CH_INDEX          = 0,
  parameter int CH_REG_START_ADDR = psec6_readout_pkg::CH_REG_START_ADDR,
  parameter int NUM_REGS_PER_CH   = psec6_readout_pkg::NUM_REGS_PER_CH,
  localparam int TS_WIDTH         = 8 * NUM_REGS_PER_CH
) (
  input  logic                spi_clk,
  input  logic                rstn,
  inout  wire                 DVDD,
  inout  wire                 DVSS,
  input  logic                cs,
  input  logic [6:0]          addr,
  input  logic                rd_en,
  input  logic [TS_WIDTH-1:0] ts_data,
  input  logic                ts_valid,
  output logic                poci_out,
  output logic                data_ready,
  output logic                ovf
);

  import psec6_readout_pkg::*;

  localparam int BASE = CH_REG_START_ADDR + CH_INDEX * NUM_REGS_PER_CH;
  localparam int LAST = BASE + NUM_REGS_PER_CH - 1;

  snap_state_t         r_state;
  snap_state_t         w_state_next;
  logic [TS_WIDTH-1:0] r_snap;
  logic                r_ovf;
  logic                w_ovf_next;
  logic                w_capture;
  logic [2:0]          r_offset;
  logic [2:0]          w_k;
  logic                w_match;
  logic                w_load;
  logic                w_wrap;
  logic                w_release;
  logic [7:0]          w_load_byte;
  logic [7:0]          w_bytes [8];
  logic                w_unused_power;

  assign w_unused_power = &{1'b0, DVDD, DVSS};

  assign w_match = (int'(addr) >= BASE) && (int'(addr) <= LAST);
  assign w_k     = 3'(addr - 7'(BASE));

  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    if (gi < NUM_REGS_PER_CH) begin : g_live
      assign w_bytes[gi] = r_snap[8*gi +: 8];
    end else begin : g_pad
      assign w_bytes[gi] = 8'h00;
    end
  end

  // An EMPTY channel answers reads with zeros rather than stale data.
  assign w_load_byte = (r_state == EMPTY) ? 8'h00 : w_bytes[w_k];

  byte_shifter u_shifter (
    .i_clk   (spi_clk),
    .i_rstn  (rstn),
    .i_cs    (cs),
    .i_rd_en (rd_en),
    .i_match (w_match),
    .i_byte  (w_load_byte),
    .o_load  (w_load),
    .o_wrap  (w_wrap),
    .o_sdo   (poci_out)
  );

  assign w_release = (r_state == LOCKED) && w_wrap &&
                     (r_offset == 3'(NUM_REGS_PER_CH - 1));

  always_comb begin
    w_state_next = r_state;
    w_ovf_next   = r_ovf;
    w_capture    = 1'b0;
    case (r_state)
      EMPTY: begin
        if (ts_valid) begin
          w_capture    = 1'b1;
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        if (w_load) begin
          w_state_next = LOCKED;
          if (ts_valid) w_ovf_next = 1'b1;
        end else if (ts_valid) begin
          w_capture  = 1'b1;
          w_ovf_next = 1'b1;
        end
      end
      LOCKED: begin
        if (!cs) begin
          w_state_next = ARMED;
          if (ts_valid) w_ovf_next = 1'b1;
        end else if (w_release) begin
          // A capture on the release edge is a fresh snapshot, not an overflow.
          w_ovf_next = 1'b0;
          if (ts_valid) begin
            w_capture    = 1'b1;
            w_state_next = ARMED;
          end else begin
            w_state_next = EMPTY;
          end
        end else if (ts_valid) begin
          w_ovf_next = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= EMPTY;
      r_snap   <= '0;
      r_ovf    <= 1'b0;
      r_offset <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_ovf   <= w_ovf_next;
      if (w_capture) r_snap <= ts_data;
      if (w_load) r_offset <= w_k;
    end
  end

  assign data_ready = (r_state != EMPTY);
  assign ovf        = r_ovf;

endmodule

// File: doc/ch_timestamp_serializer.md
# ch_timestamp_serializer

Per-channel readout source that drives one bit of the channel POCI bus (`poci_ch[CH_INDEX]`) into the readout multiplexer. It captures a 56-bit timestamp snapshot from the channel's counter and holds it as seven 8-bit SPI-addressable registers. When the SPI host reads one of those registers, the block shifts the selected byte out MSB-first on `spi_clk`. One instance sits per channel, with 8 instances per chip.

## Interface
Parameters:
- CH_INDEX, 0: channel number, 0..7.
- CH_REG_START_ADDR, 12: first channel-based register address.
- NUM_REGS_PER_CH, 7: registers per channel.
- TS_WIDTH, derived as 8*NUM_REGS_PER_CH = 56: snapshot width. Localparam, not overridable.

Ports:
- spi_clk  in  1: single clock, the SPI clock.
- rstn  in  1: reset, asynchronous assert, active-low.
- DVDD, DVSS  inout  1: local power.
- cs  in  1: SPI chip select, active-high frame qualifier, sampled synchronously.
- addr  in  7: current SPI register address, valid during the data phase.
- rd_en  in  1: high on each `spi_clk` edge of a read data phase.
- ts_data  in  56: channel timestamp, already in the `spi_clk` domain.
- ts_valid  in  1: one-cycle capture strobe for `ts_data`.
- poci_out  out  1: serialized bit, connects to `poci_ch[CH_INDEX]`.
- data_ready  out  1: an unread snapshot is held.
- ovf  out  1: sticky flag, a timestamp was lost or overwritten.

## Operation
- BASE = CH_REG_START_ADDR + CH_INDEX*NUM_REGS_PER_CH.
- Register match: BASE ≤ addr ≤ BASE+6.
- Offset k = addr − BASE selects byte `snap[8k+7:8k]`, so offset 0 is the LSB byte.
- Snapshot FSM states: EMPTY, ARMED, LOCKED. `data_ready` = (state != EMPTY).
  - EMPTY -> ARMED on `ts_valid`: `snap <= ts_data`.
  - ARMED + `ts_valid`: overwrite `snap`; set `ovf`.
  - ARMED or LOCKED -> LOCKED on a byte load (see below) at any matching offset.
  - LOCKED + `ts_valid`: timestamp dropped, `snap` unchanged; set `ovf`.
  - LOCKED -> EMPTY when the 8th bit of offset 6 has been shifted, i.e. the edge where the counter wraps with offset 6 loaded. `ovf` clears on this same edge.
  - Any state + cs low: LOCKED -> ARMED (read aborted, data kept); EMPTY and ARMED are unchanged.
- Shifter: 8-bit `sh`, 3-bit `bcnt`, plus the latched offset.
  - Edge with cs & rd_en & match & bcnt==0: load `sh <= byte(k)`, latch k, `bcnt <= 1`.
  - Edge with cs & rd_en & bcnt!=0: `sh <= sh<<1`, `bcnt++`, wrapping 7->0. Address match is not re-checked mid-byte.
  - rd_en low: `sh` and `bcnt` hold.
  - cs low: `bcnt <= 0`, `sh <= 0`.
  - A read in EMPTY state loads 8'h00 and does not lock.
- `poci_out = sh[7]`, registered.

## Timing
- Reset values: state EMPTY, `snap` 0, `sh` 0, `bcnt` 0, `poci_out` 0, `data_ready` 0, `ovf` 0.
- Bit 7 of the byte is valid after the load edge. Bit 7−n is valid after the n-th shift edge. This matches the one-cycle registered address in the downstream mux.
- Back-to-back bytes are supported: with auto-incremented addr, the edge after the 8th bit loads the next offset with no gap.
- `ts_valid` on the same edge as a lock-entering load: the load wins, the timestamp is dropped, and `ovf` is set.
- `ts_valid` on the same edge as the LOCKED->EMPTY release: the capture is accepted and the state goes to ARMED, `ovf` stays 0, and `ovf` still clears from its prior value.
- cs deasserted mid-byte: the shifter clears on the next edge and `poci_out` is 0 one cycle later.
- rstn asserted mid-read: all state clears immediately (asynchronously).
- A full readout takes 56 `rd_en` edges (offsets 0..6).

## Structure
- Shared package `psec6_readout_pkg` holds:
  - constants `CH_REG_START_ADDR`, `NUM_REGS_PER_CH`, `NUM_CH = 8`;
  - the `snap_state_t` enum {EMPTY, ARMED, LOCKED};
  - a function `ch_base(idx)`.
- The readout mux reuses the same package constants.
- One sub-module, `byte_shifter`: the 8-bit load/shift register plus `bcnt` and the wrap strobe. The snapshot FSM stays in the top module.

## Test plan
- Reset release: `poci_out`, `data_ready` and `ovf` are all 0. A read of addr 26 with CH_INDEX=2 and EMPTY state shifts out 8'h00.
- CH_INDEX=2, `ts_data = 56'h0123456789ABCD`, `ts_valid` pulse, then reads of addr 26..32 back-to-back -> bytes CD, AB, 89, 67, 45, 23, 01 MSB-first. `data_ready` falls on the 56th edge and `ovf` = 0.
- Read addr 25 or addr 33 -> no load, `poci_out` stays 0, and the state remains ARMED.
- Two `ts_valid` pulses with no read -> `snap` holds the second value and `ovf` = 1. A complete readout then clears `ovf`.
- `ts_valid` while LOCKED (after the addr 26 load) -> the first snapshot is read out intact and `ovf` = 1 until release.
- cs dropped after 3 bits of addr 28 -> `poci_out` = 0 and the state is ARMED. A re-read of 26..32 returns the full original snapshot.
